cordic_bus_regs: RTL and testbench

Memory-mapped register bank between the host bus and the CORDIC controller. It holds the operand and control words the controller samples, and captures the control/flag word and results the controller writes back. It also turns the controller's one-cycle interrupt pulse into a sticky, host-clearable interrupt line. It sits directly upstream of the controller and drives its `busPort` inputs.

---
 rtl/cordic_pkg.sv | 47 ++++
 rtl/cordic_bus_regs_if.sv | 28 ++
 rtl/bus_resp_slot.sv | 47 ++++
 rtl/cordic_bus_regs.sv | 170 +++++++++++++++++
 tb/tb_cordic_bus_regs.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/cordic_pkg.sv
// cordic_pkg: constants shared by the CORDIC controller and its host register bank.
//   - Register word addresses of the host-visible map.
//   - CTRL and flag bit positions (p_CNTRL_*, p_FLAG_*).
//   - STATUS bit positions and the CTRL reset word.
//   - A helper that merges a host CTRL write into the shadow word.
package cordic_pkg;

  // Host register map (word addresses)
  localparam int unsigned p_ADDR_CTRL   = 0;
  localparam int unsigned p_ADDR_X      = 1;
  localparam int unsigned p_ADDR_Y      = 2;
  localparam int unsigned p_ADDR_Z      = 3;
  localparam int unsigned p_ADDR_STATUS = 4;

  // CTRL word layout
  localparam int unsigned p_CNTRL_START    = 0;
  localparam int unsigned p_CNTRL_STOP     = 1;
  localparam int unsigned p_CNTRL_MODE     = 2;
  localparam int unsigned p_CNTRL_COORD    = 3;
  localparam int unsigned p_CNTRL_EN_LSB   = 4;
  localparam int unsigned p_CNTRL_ITER_LSB = 8;
  localparam int unsigned p_CNTRL_ITER_W   = 5;
  localparam int unsigned p_CNTRL_EN_HI    = 13;
  localparam int unsigned p_FLAG_READY     = 16;

  // STATUS word layout
  localparam int unsigned p_STATUS_IRQ       = 0;
  localparam int unsigned p_STATUS_RES_VALID = 1;

  // Ready=1, iterations=31, all enables set, Start=Stop=0
  localparam logic [31:0] p_CTRL_RESET = 32'h0001_3FF0;

  // Host CTRL write: while busy only Stop is accepted, while idle the low half is replaced.
  // The upper half always belongs to the controller.
  function automatic logic [31:0] f_ctrl_host_write(logic [31:0] i_ctrl, logic [15:0] i_wdata,
                                                    logic i_busy);
    logic [31:0] w_ctrl;
    w_ctrl = i_ctrl;
    if (i_busy) begin
      w_ctrl[p_CNTRL_STOP] = i_wdata[p_CNTRL_STOP];
    end else begin
      w_ctrl[15:0] = i_wdata;
    end
    return w_ctrl;
  endfunction

endpackage

// File: rtl/cordic_bus_regs_if.sv
// cordic_bus_regs_if: host request/response bus of the CORDIC register bank.
//   Request : busValid/busReady handshake with busWrite, busAddr, busWdata.
//   Response: respValid/respReady handshake with respRdata, respErr.
//   master = host side, slave = register bank side.
interface cordic_bus_regs_if #(
  parameter int unsigned p_WIDTH      = 32,
  parameter int unsigned p_ADDR_WIDTH = 3
);
  logic                    busValid;
  logic                    busReady;
  logic                    busWrite;
  logic [p_ADDR_WIDTH-1:0] busAddr;
  logic [p_WIDTH-1:0]      busWdata;
  logic                    respValid;
  logic                    respReady;
  logic [p_WIDTH-1:0]      respRdata;
  logic                    respErr;

  modport master (
    output busValid, busWrite, busAddr, busWdata, respReady,
    input  busReady, respValid, respRdata, respErr
  );

  modport slave (
    input  busValid, busWrite, busAddr, busWdata, respReady,
    output busReady, respValid, respRdata, respErr
  );
endinterface

// File: rtl/bus_resp_slot.sv
// bus_resp_slot: one-entry response holding register for the host bus.
//   clk, rst       : clock, asynchronous active-low reset
//   i_load         : request accepted this cycle, capture i_rdata/i_err
//   i_resp_ready   : host takes the held response
//   o_ready        : a new request may be accepted (slot empty or draining)
//   o_valid/o_rdata/o_err : held response
module bus_resp_slot #(
  parameter int unsigned p_WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_load,
  input  logic [p_WIDTH-1:0] i_rdata,
  input  logic               i_err,
  input  logic               i_resp_ready,
  output logic               o_ready,
  output logic               o_valid,
  output logic [p_WIDTH-1:0] o_rdata,
  output logic               o_err
);

  logic               r_valid;
  logic [p_WIDTH-1:0] r_rdata;
  logic               r_err;

  // Draining and refilling in the same cycle keeps one request per cycle.
  assign o_ready = !r_valid || i_resp_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid <= 1'b0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_rdata <= i_rdata;
      r_err   <= i_err;
    end else if (i_resp_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_rdata = r_rdata;
  assign o_err   = r_err;

endmodule

// File: rtl/cordic_bus_regs.sv
// cordic_bus_regs: host register bank in front of the CORDIC controller.
//   clk, rst                   : clock, asynchronous active-low reset
//   bus                        : host request/response bus (slave side)
//   controlRegisterInput       : CTRL shadow driven to the controller
//   xInput/yInput/zInput       : operands driven to the controller
//   controlRegisterOutput      : controller CTRL/flag word
//   controlRegisterWriteEnable : controller writeback strobe
//   xResult/yResult/zResult    : controller results, captured on completion
//   interrupt                  : controller one-cycle interrupt pulse
//   irq                        : sticky host interrupt, cleared by STATUS W1C
module cordic_bus_regs
  import cordic_pkg::*;
#(
  parameter int unsigned p_WIDTH      = 32,
  parameter int unsigned p_ADDR_WIDTH = 3
) (
  input  logic               clk,
  input  logic               rst,
  cordic_bus_regs_if.slave   bus,
  output logic [31:0]        controlRegisterInput,
  output logic [p_WIDTH-1:0] xInput,
  output logic [p_WIDTH-1:0] yInput,
  output logic [p_WIDTH-1:0] zInput,
  input  logic [31:0]        controlRegisterOutput,
  input  logic               controlRegisterWriteEnable,
  input  logic [p_WIDTH-1:0] xResult,
  input  logic [p_WIDTH-1:0] yResult,
  input  logic [p_WIDTH-1:0] zResult,
  input  logic               interrupt,
  output logic               irq
);

  logic [31:0]        r_ctrl;
  logic [p_WIDTH-1:0] r_x_op, r_y_op, r_z_op;
  logic [p_WIDTH-1:0] r_x_res, r_y_res, r_z_res;
  logic               r_result_valid;
  logic               r_irq_pending;

  logic               w_bus_ready;
  logic               w_accept;
  logic               w_busy;
  logic               w_completion;
  logic [31:0]        w_addr;
  logic [31:0]        w_ctrl_next;
  logic [2:0]         w_op_load;
  logic               w_irq_clr;
  logic               w_clear_rv;
  logic [p_WIDTH-1:0] w_rdata;
  logic               w_err;

  assign w_accept     = bus.busValid && w_bus_ready;
  assign w_busy       = !r_ctrl[p_FLAG_READY];
  assign w_addr       = 32'(bus.busAddr);
  // A writeback that raises Ready while we considered the controller busy marks completion.
  assign w_completion = controlRegisterWriteEnable && w_busy
                        && controlRegisterOutput[p_FLAG_READY];

  always_comb begin
    // Writeback first; a host CTRL write overlays it using the pre-update busy state.
    w_ctrl_next = controlRegisterWriteEnable ? controlRegisterOutput : r_ctrl;
    w_op_load   = 3'b000;
    w_irq_clr   = 1'b0;
    w_clear_rv  = 1'b0;
    w_rdata     = '0;
    w_err       = 1'b0;
    if (w_accept) begin
      unique case (w_addr)
        p_ADDR_CTRL: begin
          if (bus.busWrite) begin
            w_ctrl_next = f_ctrl_host_write(w_ctrl_next, bus.busWdata[15:0], w_busy);
            w_clear_rv  = !w_busy && bus.busWdata[p_CNTRL_START];
          end else begin
            w_rdata = p_WIDTH'(r_ctrl);
          end
        end
        p_ADDR_X: begin
          if (bus.busWrite) begin
            w_err        = w_busy;
            w_op_load[0] = !w_busy;
          end else begin
            w_rdata = r_x_res;
          end
        end
        p_ADDR_Y: begin
          if (bus.busWrite) begin
            w_err        = w_busy;
            w_op_load[1] = !w_busy;
          end else begin
            w_rdata = r_y_res;
          end
        end
        p_ADDR_Z: begin
          if (bus.busWrite) begin
            w_err        = w_busy;
            w_op_load[2] = !w_busy;
          end else begin
            w_rdata = r_z_res;
          end
        end
        p_ADDR_STATUS: begin
          if (bus.busWrite) begin
            w_irq_clr = bus.busWdata[p_STATUS_IRQ];
          end else begin
            w_rdata = p_WIDTH'({r_result_valid, r_irq_pending});
          end
        end
        default: w_err = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ctrl         <= p_CTRL_RESET;
      r_x_op         <= '0;
      r_y_op         <= '0;
      r_z_op         <= '0;
      r_x_res        <= '0;
      r_y_res        <= '0;
      r_z_res        <= '0;
      r_result_valid <= 1'b0;
      r_irq_pending  <= 1'b0;
    end else begin
      r_ctrl <= w_ctrl_next;
      if (w_op_load[0]) r_x_op <= bus.busWdata;
      if (w_op_load[1]) r_y_op <= bus.busWdata;
      if (w_op_load[2]) r_z_op <= bus.busWdata;
      if (w_completion) begin
        r_x_res <= xResult;
        r_y_res <= yResult;
        r_z_res <= zResult;
      end
      // Completion needs busy, a clearing Start write needs idle: never both.
      if (w_completion) begin
        r_result_valid <= 1'b1;
      end else if (w_clear_rv) begin
        r_result_valid <= 1'b0;
      end
      // A coincident interrupt pulse beats the host clear.
      if (interrupt) begin
        r_irq_pending <= 1'b1;
      end else if (w_irq_clr) begin
        r_irq_pending <= 1'b0;
      end
    end
  end

  bus_resp_slot #(
    .p_WIDTH(p_WIDTH)
  ) u_resp_slot (
    .clk          (clk),
    .rst          (rst),
    .i_load       (w_accept),
    .i_rdata      (w_rdata),
    .i_err        (w_err),
    .i_resp_ready (bus.respReady),
    .o_ready      (w_bus_ready),
    .o_valid      (bus.respValid),
    .o_rdata      (bus.respRdata),
    .o_err        (bus.respErr)
  );

  assign bus.busReady         = w_bus_ready;
  assign controlRegisterInput = r_ctrl;
  assign xInput               = r_x_op;
  assign yInput               = r_y_op;
  assign zInput               = r_z_op;
  assign irq                  = r_irq_pending;

endmodule

// File: tb/tb_cordic_bus_regs.sv
// tb_cordic_bus_regs: scoreboard bench for cordic_bus_regs. A behavioural model of the register
// map runs on every accepting edge and queues the expected response; a negedge monitor pops and
// compares responses and checks the controller-facing outputs against the model state.
module tb_cordic_bus_regs;

  localparam int unsigned W  = 32;
  localparam int unsigned AW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [31:0]   ctrl_in;
  logic [W-1:0]  x_in, y_in, z_in;
  logic [31:0]   ctrl_out;
  logic          cwe;
  logic [W-1:0]  x_res, y_res, z_res;
  logic          intr;
  logic          irq;

  always #5 clk = ~clk;

  cordic_bus_regs_if #(.p_WIDTH(W), .p_ADDR_WIDTH(AW)) bus ();

  cordic_bus_regs #(
    .p_WIDTH      (W),
    .p_ADDR_WIDTH (AW)
  ) dut (
    .clk                        (clk),
    .rst                        (rst),
    .bus                        (bus.slave),
    .controlRegisterInput       (ctrl_in),
    .xInput                     (x_in),
    .yInput                     (y_in),
    .zInput                     (z_in),
    .controlRegisterOutput      (ctrl_out),
    .controlRegisterWriteEnable (cwe),
    .xResult                    (x_res),
    .yResult                    (y_res),
    .zResult                    (z_res),
    .interrupt                  (intr),
    .irq                        (irq)
  );

  // Reference model state
  logic [31:0] m_ctrl;
  logic [31:0] m_op  [3];
  logic [31:0] m_res [3];
  bit          m_rv, m_irqp, m_pend, m_last_accept;
  logic [32:0] exp_q [$];   // {err, rdata}
  logic [32:0] mon_e;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ctrl = 32'h0001_3FF0;
    for (int i = 0; i < 3; i++) begin
      m_op[i]  = '0;
      m_res[i] = '0;
    end
    m_rv          = 0;
    m_irqp        = 0;
    m_pend        = 0;
    m_last_accept = 0;
    exp_q.delete();
  endtask

  // One accepting edge of the register map, computed from the register-map rules.
  task automatic model_step();
    bit          busy   = !m_ctrl[16];
    bit          acc    = bus.busValid && (!m_pend || bus.respReady);
    int          a      = int'(bus.busAddr);
    logic [31:0] nctrl  = cwe ? ctrl_out : m_ctrl;
    logic [31:0] rd     = '0;
    bit          er     = 0;
    bit          clr_rv = 0;
    bit          w1c    = 0;
    if (acc) begin
      if (a == 0) begin
        if (bus.busWrite) begin
          if (busy) nctrl[1] = bus.busWdata[1];
          else begin
            nctrl[15:0] = bus.busWdata[15:0];
            clr_rv      = bus.busWdata[0];
          end
        end else rd = m_ctrl;
      end else if (a >= 1 && a <= 3) begin
        if (bus.busWrite) begin
          if (busy) er = 1;
          else m_op[a-1] = bus.busWdata;
        end else rd = m_res[a-1];
      end else if (a == 4) begin
        if (bus.busWrite) w1c = bus.busWdata[0];
        else rd = {30'd0, m_rv, m_irqp};
      end else er = 1;
      exp_q.push_back({er, rd});
    end
    if (cwe && busy && ctrl_out[16]) begin
      m_res = '{x_res, y_res, z_res};
      m_rv  = 1;
    end else if (clr_rv) m_rv = 0;
    if (intr) m_irqp = 1;
    else if (w1c) m_irqp = 0;
    m_ctrl = nctrl;
    if (acc) m_pend = 1;
    else if (bus.respReady) m_pend = 0;
    m_last_accept = acc;
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) model_step();
    else m_last_accept = 0;
    #1;
  endtask

  task automatic req(input bit wr, input int addr, input logic [31:0] wd);
    bus.busValid = 1;
    bus.busWrite = wr;
    bus.busAddr  = AW'(addr);
    bus.busWdata = wd;
    for (int n = 0; n < 100; n++) begin
      tick();
      if (m_last_accept) break;
    end
    if (!m_last_accept) check("req_timeout", 64'd1, 64'd0);
    bus.busValid = 0;
  endtask

  task automatic writeback(input logic [31:0] cw, input logic [31:0] xr);
    cwe      = 1;
    ctrl_out = cw;
    x_res    = xr;
    y_res    = xr + 32'd1;
    z_res    = xr + 32'd2;
    tick();
    cwe = 0;
  endtask

  // Monitor: compare everything the DUT presents against the model on the falling edge.
  always @(negedge clk) begin
    check("busReady", 64'(bus.busReady), 64'(!m_pend || bus.respReady));
    check("respValid", 64'(bus.respValid), 64'(m_pend));
    check("ctrlInput", 64'(ctrl_in), 64'(m_ctrl));
    check("xInput", 64'(x_in), 64'(m_op[0]));
    check("yInput", 64'(y_in), 64'(m_op[1]));
    check("zInput", 64'(z_in), 64'(m_op[2]));
    check("irq", 64'(irq), 64'(m_irqp));
    if (bus.respValid && bus.respReady) begin
      if (exp_q.size() == 0) begin
        check("unexpected_resp", 64'd1, 64'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("respRdata", 64'(bus.respRdata), 64'(mon_e[31:0]));
        check("respErr", 64'(bus.respErr), 64'(mon_e[32]));
      end
    end
  end

  initial begin
    rst           = 1;
    bus.busValid  = 0;
    bus.busWrite  = 0;
    bus.busAddr   = '0;
    bus.busWdata  = '0;
    bus.respReady = 1;
    cwe           = 0;
    ctrl_out      = '0;
    x_res         = '0;
    y_res         = '0;
    z_res         = '0;
    intr          = 0;
    #2 rst = 0;
    model_reset();
    tick();
    tick();
    rst = 1;
    tick();

    // Reset values
    req(0, 0, 0);
    req(0, 4, 0);
    tick();

    // Operand load, then Start; controller acknowledges with Ready=0, Start cleared
    req(1, 1, 32'h1000_0000);
    req(1, 0, 32'h0000_1F0D);
    tick();
    writeback(32'h0000_1F0C, 32'h0);
    tick();

    // Busy: operand write rejected, Stop taken
    req(1, 2, 32'h0000_DEAD);
    req(1, 0, 32'h0000_0002);
    tick();

    // Completion
    writeback(32'h0001_1F0C, 32'h0000_1234);
    req(0, 1, 0);
    req(0, 2, 0);
    req(0, 4, 0);

    // Interrupt coincident with W1C, then a clean W1C
    intr = 1;
    req(1, 4, 1);
    intr = 0;
    req(0, 4, 0);
    req(1, 4, 1);
    req(0, 4, 0);

    // Response backpressure: second request stalls until the first is taken
    tick();
    bus.respReady = 0;
    req(0, 0, 0);
    bus.busValid = 1;
    bus.busWrite = 0;
    bus.busAddr  = AW'(6);
    repeat (3) tick();
    bus.respReady = 1;
    req(0, 6, 0);
    tick();

    // Reset with a response pending
    bus.respReady = 0;
    req(0, 1, 0);
    rst = 0;
    model_reset();
    tick();
    tick();
    rst = 1;
    bus.respReady = 1;
    tick();
    req(0, 0, 0);

    // Randomized traffic
    for (int c = 0; c < 1500; c++) begin
      bus.busValid  = ($urandom_range(0, 1) == 1);
      bus.busWrite  = ($urandom_range(0, 1) == 1);
      bus.busAddr   = AW'($urandom_range(0, 7));
      bus.busWdata  = $urandom;
      bus.respReady = ($urandom_range(0, 3) != 0);
      cwe           = ($urandom_range(0, 9) == 0);
      ctrl_out      = $urandom;
      x_res         = $urandom;
      y_res         = $urandom;
      z_res         = $urandom;
      intr          = ($urandom_range(0, 9) == 0);
      tick();
    end

    bus.busValid  = 0;
    bus.respReady = 1;
    cwe           = 0;
    intr          = 0;
    repeat (3) tick();
    check("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
